lmsm_sequencer: RTL

Parametrised block-transfer sequencer for load-multiple and store-multiple instructions. It moves a masked set of register-file entries to or from consecutive memory words, in ascending or descending order, using a req/ack memory handshake that tolerates wait states. The main multicycle controller launches it with a single start pulse and waits for done. This generalises the fixed 8-register, fixed-order, zero-wait LM/SM loop formerly embedded in the controller FSM.

---
 rtl/lmsm_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lmsm_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lmsm_sequencer
// Purpose  : Load/store-multiple block transfer sequencer (masked RF <-> memory)
// Revision : 1.0 - initial release
// ============================================================================
module lmsm_sequencer #(
    parameter int NUM_REGS  = 8,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int ADDR_STEP = 1,
    parameter int IDX_W     = $clog2(NUM_REGS),
    parameter int CNT_W     = $clog2(NUM_REGS + 1)
) (
    input  logic                clk,
    input  logic                proc_rst,
    input  logic                start,
    input  logic                mode_store,
    input  logic                dir_down,
    input  logic [NUM_REGS-1:0] reg_mask,
    input  logic [ADDR_W-1:0]   base_addr,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    rf_idx,
    output logic                rf_ren,
    input  logic [DATA_W-1:0]   rf_rdata,
    output logic                rf_wen,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic [CNT_W-1:0]    xfer_count,
    output logic [ADDR_W-1:0]   end_addr
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_MEM  = 3'd2,
        S_WB   = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NUM_REGS-1:0] r_rem_mask;
    logic                r_mode_store;
    logic                r_dir_down;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [CNT_W-1:0]    r_xfer_count;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_rf_wdata;

    logic [IDX_W-1:0]    w_cur_idx;
    logic [NUM_REGS-1:0] w_mask_cleared;
    logic [ADDR_W-1:0]   w_next_addr;
    logic                w_retire;

    // The mask bit under service is only cleared on retire, so the encoder
    // output stays valid as the current index through SEL, MEM and WB.
    always_comb begin
        w_cur_idx = '0;
        if (r_dir_down) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_rem_mask[i]) w_cur_idx = IDX_W'(i);
            end
        end else begin
            for (int i = NUM_REGS - 1; i >= 0; i--) begin
                if (r_rem_mask[i]) w_cur_idx = IDX_W'(i);
            end
        end
    end

    assign w_mask_cleared = r_rem_mask & ~(NUM_REGS'(1) << w_cur_idx);
    assign w_next_addr    = r_dir_down ? (r_cur_addr - ADDR_W'(ADDR_STEP))
                                       : (r_cur_addr + ADDR_W'(ADDR_STEP));
    assign w_retire       = (r_state == S_WB) ||
                            ((r_state == S_MEM) && mem_ack && r_mode_store);

    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE);
        mem_req      = (r_state == S_MEM);
        rf_ren       = (r_state == S_SEL) && r_mode_store;
        rf_wen       = (r_state == S_WB);
        rf_idx       = w_cur_idx;
        mem_we       = r_mode_store;
        mem_addr     = r_cur_addr;
        mem_wdata    = r_mem_wdata;
        rf_wdata     = r_rf_wdata;
        xfer_count   = r_xfer_count;
        end_addr     = r_cur_addr;
        case (r_state)
            S_IDLE: if (start) w_state_next = (|reg_mask) ? S_SEL : S_DONE;
            S_SEL:  w_state_next = S_MEM;
            S_MEM: begin
                if (mem_ack) begin
                    if (!r_mode_store)        w_state_next = S_WB;
                    else if (|w_mask_cleared) w_state_next = S_SEL;
                    else                      w_state_next = S_DONE;
                end
            end
            S_WB:   w_state_next = (|w_mask_cleared) ? S_SEL : S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            r_rem_mask   <= '0;
            r_mode_store <= 1'b0;
            r_dir_down   <= 1'b0;
            r_cur_addr   <= '0;
            r_xfer_count <= '0;
            r_mem_wdata  <= '0;
            r_rf_wdata   <= '0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_rem_mask   <= reg_mask;
                r_mode_store <= mode_store;
                r_dir_down   <= dir_down;
                r_cur_addr   <= base_addr;
                r_xfer_count <= '0;
            end
            if ((r_state == S_SEL) && r_mode_store) r_mem_wdata <= rf_rdata;
            if ((r_state == S_MEM) && mem_ack && !r_mode_store) r_rf_wdata <= mem_rdata;
            if (w_retire) begin
                r_rem_mask   <= w_mask_cleared;
                r_cur_addr   <= w_next_addr;
                r_xfer_count <= r_xfer_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire
